// File: rtl/cdc_glitch_filter.sv
// Glitch filter for an already-synchronized level: the filtered level only follows
// the input after FILT_CNT consecutive differing samples; shorter excursions are counted.
module cdc_glitch_filter #(
   parameter int   FILT_CNT = 4,
   parameter logic RST_VAL  = 1'b0,
   parameter int   CNT_W    = $clog2(FILT_CNT + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       sync_in,
   input  logic       clr_cnt,
   output logic       filt_out,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       glitch_pulse,
   output logic [7:0] glitch_cnt
);

   typedef enum logic {STABLE = 1'b0, QUALIFY = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             filt_nxt, rise_nxt, fall_nxt, glitch_nxt;
   logic [7:0]       gcnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= STABLE;
         cnt          <= '0;
         filt_out     <= RST_VAL;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         glitch_pulse <= 1'b0;
         glitch_cnt   <= 8'd0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         filt_out     <= filt_nxt;
         rise_pulse   <= rise_nxt;
         fall_pulse   <= fall_nxt;
         glitch_pulse <= glitch_nxt;
         glitch_cnt   <= gcnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      filt_nxt   = filt_out;
      rise_nxt   = 1'b0;
      fall_nxt   = 1'b0;
      glitch_nxt = 1'b0;
      gcnt_nxt   = glitch_cnt;
      if (!en) begin
         // disabling abandons any excursion without counting it
         state_nxt = STABLE;
         cnt_nxt   = '0;
      end else if (sync_in != filt_out) begin
         if (cnt == CNT_LAST) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
            filt_nxt  = sync_in;
            rise_nxt  = sync_in;
            fall_nxt  = ~sync_in;
         end else begin
            state_nxt = QUALIFY;
            cnt_nxt   = cnt + 1'b1;
         end
      end else if (state == QUALIFY) begin
         state_nxt  = STABLE;
         cnt_nxt    = '0;
         glitch_nxt = 1'b1;
         if (glitch_cnt != 8'hFF) gcnt_nxt = glitch_cnt + 8'd1;
      end
      if (clr_cnt) gcnt_nxt = 8'd0;
   end

endmodule

// File: tb/tb_cdc_glitch_filter.sv
// Directed + random bench: FILT_CNT=4 instance against a queue-based excursion model,
// FILT_CNT=1 instance against a one-sample delay of its input.
module tb_cdc_glitch_filter;

   localparam int F4 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, sync_in, clr_cnt;
   logic       filt_out, rise_pulse, fall_pulse, glitch_pulse;
   logic [7:0] glitch_cnt;

   logic       en1, sync1, clr1;
   logic       filt1, rise1, fall1, glitch1;
   logic [7:0] gcnt1;

   cdc_glitch_filter #(.FILT_CNT(F4), .RST_VAL(1'b0)) u_dut (
      .clk(clk), .rst(rst), .en(en), .sync_in(sync_in), .clr_cnt(clr_cnt),
      .filt_out(filt_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .glitch_pulse(glitch_pulse), .glitch_cnt(glitch_cnt));

   cdc_glitch_filter #(.FILT_CNT(1), .RST_VAL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .en(en1), .sync_in(sync1), .clr_cnt(clr1),
      .filt_out(filt1), .rise_pulse(rise1), .fall_pulse(fall1),
      .glitch_pulse(glitch1), .glitch_cnt(gcnt1));

   int n_cmp = 0;
   int n_err = 0;

   // reference state: current excursion kept as the list of differing samples
   bit m_filt, m_rise, m_fall, m_glitch;
   int m_gcnt;
   bit exc[$];
   bit m1_filt, m1_rise, m1_fall;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_filt = 1'b0; m_rise = 0; m_fall = 0; m_glitch = 0; m_gcnt = 0;
         exc.delete();
         m1_filt = 1'b0; m1_rise = 0; m1_fall = 0;
      end else begin
         m_rise = 0; m_fall = 0; m_glitch = 0;
         if (!en) exc.delete();
         else if (sync_in != m_filt) begin
            exc.push_back(sync_in);
            if (exc.size() == F4) begin
               m_filt = sync_in; m_rise = sync_in; m_fall = !sync_in;
               exc.delete();
            end
         end else if (exc.size() > 0) begin
            m_glitch = 1;
            exc.delete();
            if (m_gcnt < 255) m_gcnt++;
         end
         if (clr_cnt) m_gcnt = 0;
         m1_rise = sync1 & ~m1_filt;
         m1_fall = ~sync1 & m1_filt;
         m1_filt = sync1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("filt", filt_out, m_filt);
      check("rise", rise_pulse, m_rise);
      check("fall", fall_pulse, m_fall);
      check("glitch", glitch_pulse, m_glitch);
      check("gcnt", glitch_cnt, m_gcnt[7:0]);
      check("f1_filt", filt1, m1_filt);
      check("f1_rise", rise1, m1_rise);
      check("f1_fall", fall1, m1_fall);
      check("f1_glitch", glitch1, 1'b0);
      check("f1_gcnt", gcnt1, 8'd0);
      sync1 = 1'($urandom_range(0, 1));
   endtask

   initial begin
      rst = 1; en = 1; sync_in = 0; clr_cnt = 0;
      en1 = 1; sync1 = 0; clr1 = 0;
      m_filt = 0; m_gcnt = 0;

      // reset held with toggling input
      for (int i = 0; i < 3; i++) begin
         sync_in = ~sync_in;
         tick();
         check("rst_filt", filt_out, 1'b0);
         check("rst_gcnt", glitch_cnt, 8'd0);
      end
      rst = 0; sync_in = 0;
      tick();
      check("rel_filt", filt_out, 1'b0);

      // clean rise: new value seen on the 4th edge only
      sync_in = 1;
      for (int i = 0; i < 3; i++) tick();
      check("rise_early", filt_out, 1'b0);
      tick();
      check("rise_filt", filt_out, 1'b1);
      check("rise_pulse", rise_pulse, 1'b1);
      tick();
      check("rise_once", rise_pulse, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      sync_in = 0;
      for (int i = 0; i < 3; i++) tick();
      check("fall_early", fall_pulse, 1'b0);
      tick();
      check("fall_pulse", fall_pulse, 1'b1);
      check("fall_filt", filt_out, 1'b0);
      tick();

      // 3-sample and 1-sample excursions are rejected
      sync_in = 1;
      for (int i = 0; i < 3; i++) tick();
      sync_in = 0;
      tick();
      check("g3_pulse", glitch_pulse, 1'b1);
      check("g3_cnt", glitch_cnt, 8'd1);
      check("g3_filt", filt_out, 1'b0);
      tick();
      check("g3_once", glitch_pulse, 1'b0);
      sync_in = 1; tick();
      sync_in = 0; tick();
      check("g1_cnt", glitch_cnt, 8'd2);

      // saturation, then clear colliding with an increment
      for (int i = 0; i < 260; i++) begin
         sync_in = 1; tick();
         sync_in = 0; tick();
      end
      check("sat_cnt", glitch_cnt, 8'd255);
      sync_in = 1; tick();
      sync_in = 0; clr_cnt = 1; tick();
      check("clr_cnt", glitch_cnt, 8'd0);
      check("clr_pulse", glitch_pulse, 1'b1);
      clr_cnt = 0; tick();

      // en=0 mid-excursion: not a glitch, qualification restarts
      sync_in = 1; tick(); tick();
      en = 0;
      for (int i = 0; i < 5; i++) tick();
      en = 1;
      for (int i = 0; i < 3; i++) tick();
      check("en_early", filt_out, 1'b0);
      check("en_gcnt", glitch_cnt, 8'd0);
      tick();
      check("en_filt", filt_out, 1'b1);

      // reset mid-qualification
      sync_in = 0; tick(); tick();
      rst = 1; tick();
      check("mrst_filt", filt_out, 1'b0);
      rst = 0; sync_in = 1;
      for (int i = 0; i < 3; i++) tick();
      check("mrst_early", filt_out, 1'b0);
      tick();
      check("mrst_filt1", filt_out, 1'b1);

      // random runs of varying length, occasional en/clr/rst
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 3) == 0) sync_in = ~sync_in;
         en      = ($urandom_range(0, 15) != 0);
         clr_cnt = ($urandom_range(0, 63) == 0);
         rst     = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdc_glitch_filter.md
Name: cdc_glitch_filter

Overview:
Downstream consumer of the 2-FF synchronizer output, placed in the destination clock domain. Rejects pulses shorter than a programmable number of cycles on the synchronized JTAG or control level. Emits a clean filtered level, single-cycle rise and fall strobes, and glitch diagnostics. Used for the synchronized TRST/TMS-style levels and external request lines before they reach the control FSMs.

Parameters:
FILT_CNT, 4, consecutive cycles the input must differ from the filtered level before the filtered level flips; legal range 1..255
RST_VAL, 1'b0, value of filt_out during and after reset
CNT_W, $clog2(FILT_CNT+1), width of the internal qualification counter; derived, do not override

Ports:
clk  input  1  destination-domain clock
rst  input  1  synchronous, active-high reset
en  input  1  filter enable; 0 freezes filt_out and suppresses all strobes
sync_in  input  1  already-synchronized level (2-FF synchronizer output)
clr_cnt  input  1  single-cycle request to clear glitch_cnt
filt_out  output  1  filtered level
rise_pulse  output  1  one-cycle strobe when filt_out goes 0->1
fall_pulse  output  1  one-cycle strobe when filt_out goes 1->0
glitch_pulse  output  1  one-cycle strobe when a rejected excursion ends
glitch_cnt  output  8  saturating count of rejected excursions

Behaviour:
- All state is updated on posedge clk. Reset is synchronous: with rst=1 at an edge, the block sets filt_out=RST_VAL, rise_pulse=fall_pulse=glitch_pulse=0, glitch_cnt=0, and counter=0. A qualification in progress is abandoned. rst has priority over every other input.
- All outputs are registered. No combinational path exists from inputs to outputs.
- The block has two states:
  - STABLE (counter=0): the last sample matched filt_out.
  - QUALIFY (counter>0): the input has differed from filt_out for `counter` consecutive samples.
- At each edge with en=1:
  - sync_in != filt_out and counter+1 == FILT_CNT: filt_out <= sync_in, counter <= 0. Assert rise_pulse if sync_in=1, otherwise fall_pulse.
  - sync_in != filt_out and counter+1 < FILT_CNT: counter <= counter+1.
  - sync_in == filt_out and counter != 0: counter <= 0, glitch_pulse <= 1, glitch_cnt <= glitch_cnt+1 (saturating at 255).
  - sync_in == filt_out and counter == 0: no change.
- Strobes are high for exactly one cycle, coincident with the first cycle in which the corresponding event is visible. At most one of rise_pulse, fall_pulse, and glitch_pulse is high in any cycle.
- Latency: suppose sync_in takes a new value before edge k and holds it. filt_out shows the new value after edge k+FILT_CNT-1, so FILT_CNT edges are consumed.
  - FILT_CNT=1 gives a single-register delay. Glitches are impossible and glitch_cnt stays 0.
- Any excursion of 1..FILT_CNT-1 samples never appears on filt_out.
- en=0 at an edge: counter <= 0, filt_out holds, all strobes 0, glitch_cnt holds.
  - An excursion interrupted by en=0 is not counted as a glitch.
  - When en returns to 1, qualification restarts from counter=0.
- clr_cnt=1 at an edge: glitch_cnt <= 0. This wins over a simultaneous increment, so the result is 0. glitch_pulse still asserts for that glitch.
- glitch_cnt at 255 stays at 255 on further glitches. glitch_pulse still strobes.
- An input toggle on the same edge that qualification completes is resolved by the sampled value. The transition-completion rule uses the sample that differs from filt_out, so a flip then occurs.

Test Plan:
- Reset, FILT_CNT=4, RST_VAL=0: hold rst=1 for 3 edges with sync_in toggling. Required: filt_out=0, all strobes 0, glitch_cnt=0 throughout. Release rst with sync_in=0: outputs unchanged.
- Clean rise then fall, FILT_CNT=4, en=1:
  - Drive sync_in 0->1 before edge 10 and hold. Required: filt_out=1 and rise_pulse=1 after edge 13 only; rise_pulse=0 after edge 14.
  - Drive sync_in 1->0 before edge 20. Required: fall_pulse after edge 23 only.
- Glitch rejection:
  - Drive sync_in=1 for 3 samples, then back to 0. Required: filt_out stays 0, glitch_pulse for 1 cycle, glitch_cnt=1.
  - Repeat with a 1-sample excursion. Required: glitch_cnt=2.
- Saturation and clear:
  - Inject 260 one-sample glitches. Required: glitch_cnt=255.
  - Assert clr_cnt on the same edge as glitch 261. Required: glitch_cnt=0, glitch_pulse=1.
- Enable and reset interruption:
  - Drive sync_in=1 for 2 samples, then en=0 for 5 cycles, then en=1 with sync_in=1 held. Required: no glitch_pulse, glitch_cnt unchanged, filt_out=1 on the 4th enabled edge.
  - Pulse rst mid-qualification. Required: filt_out=RST_VAL, qualification restarts from 0.
- FILT_CNT=1 build: random sync_in over 1000 cycles. Required: filt_out equals sync_in delayed 1 cycle, rise/fall match edges of the delayed signal, glitch_cnt=0.
